// File: rtl/button_updown_counter_pkg.sv
// Shared definitions for the debounced up/down/clear button counter.
package button_updown_counter_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_CLR  = 2'd3
  } step_e;

  localparam int DEFAULT_BOUNCING_TIME = 1250000;

endpackage

// File: rtl/button_updown_counter_btn_pulse.sv
// Raw button -> 2-flop synchroniser -> debouncer -> registered rising-edge pulse.
module btn_pulse #(
  parameter int BOUNCING_TIME = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(BOUNCING_TIME + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, pulse_q;
  logic [CW-1:0] run_q, run_d;

  // The run counter only advances while the synchronised input disagrees with
  // the accepted level; any agreement (a glitch back) restarts it from zero.
  always_comb begin
    run_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (run_q == CW'(BOUNCING_TIME - 1)) begin
        level_d = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      run_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      run_q   <= run_d;
      level_q <= level_d;
      prev_q  <= level_q;
      pulse_q <= level_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/button_updown_counter.sv
// Up/down/clear counter driven by three bouncing push-buttons, with wrap or
// saturate behaviour and one-cycle overflow/underflow flags.
module button_updown_counter
  import button_updown_counter_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int MAX_COUNT     = 2**WIDTH - 1,
  parameter int BOUNCING_TIME = DEFAULT_BOUNCING_TIME,
  parameter int WRAP          = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic             up_p, dn_p, clr_p;
  step_e            step;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  btn_pulse #(.BOUNCING_TIME(BOUNCING_TIME)) u_up (
    .clk(clk), .rst(rst), .btn_i(btn_up), .pulse_o(up_p)
  );
  btn_pulse #(.BOUNCING_TIME(BOUNCING_TIME)) u_dn (
    .clk(clk), .rst(rst), .btn_i(btn_dn), .pulse_o(dn_p)
  );
  btn_pulse #(.BOUNCING_TIME(BOUNCING_TIME)) u_clr (
    .clk(clk), .rst(rst), .btn_i(btn_clr), .pulse_o(clr_p)
  );

  // Clear wins; simultaneous up and down cancel out.
  always_comb begin
    step = STEP_HOLD;
    if (clr_p) begin
      step = STEP_CLR;
    end else if (up_p ^ dn_p) begin
      step = up_p ? STEP_INC : STEP_DEC;
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    case (step)
      STEP_CLR: count_d = '0;
      STEP_INC: begin
        if (count_q >= MAX_V) begin
          ovf_d = 1'b1;
          count_d = (WRAP != 0) ? '0 : MAX_V;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      STEP_DEC: begin
        if (count_q == '0) begin
          unf_d = 1'b1;
          if (WRAP != 0) count_d = MAX_V;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: doc/button_updown_counter.md
BUTTON_UPDOWN_COUNTER -- requirements
Module: button_updown_counter

Interface
- REQ-001 Parameter WIDTH, default 4: count width in bits; legal range 2..16.
- REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1: terminal value; legal range 1..2**WIDTH-1.
- REQ-003 Parameter BOUNCING_TIME, default 1250000: consecutive stable cycles needed before a button level is accepted; legal minimum 2.
- REQ-004 Parameter WRAP, default 1: 1 = modulo (MAX_COUNT+1) wrap; 0 = saturate at 0 and MAX_COUNT.
- REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-006 rst  input  1  synchronous, active-low reset.
- REQ-007 btn_up  input  1  raw, asynchronous, bouncing increment button, active-high.
- REQ-008 btn_dn  input  1  raw, asynchronous, bouncing decrement button, active-high.
- REQ-009 btn_clr  input  1  raw, asynchronous, bouncing clear button, active-high.
- REQ-010 count  output  WIDTH  current count, registered.
- REQ-011 ovf  output  1  one-cycle pulse on an increment step from MAX_COUNT.
- REQ-012 unf  output  1  one-cycle pulse on a decrement step from 0.

Function
- REQ-013 Each button SHALL pass through a 2-flop synchroniser, then a debouncer, then a rising-edge detector.
- REQ-014 Debouncer: the accepted level SHALL change only after the synchronised input differs from it for BOUNCING_TIME consecutive cycles; any glitch restarts the run count.
- REQ-015 Edge detector: SHALL emit a 1-cycle pulse on each 0->1 transition of the accepted level; release produces no pulse.
- REQ-016 Latency from a clean raw rising edge to the count change SHALL be exactly BOUNCING_TIME+4 clk cycles.
- REQ-017 Priority per cycle: clr pulse > (up XOR dn) > hold.
- REQ-018 A clr pulse SHALL load count=0 and suppress ovf/unf in that cycle.
- REQ-019 Simultaneous up and dn pulses (no clr) SHALL leave count unchanged with ovf=unf=0.
- REQ-020 Up below MAX_COUNT: count+1. Up at MAX_COUNT: count=0 if WRAP=1, else hold; ovf=1 in both cases.
- REQ-021 Dn above 0: count-1. Dn at 0: count=MAX_COUNT if WRAP=1, else hold; unf=1 in both cases.
- REQ-022 ovf and unf SHALL be registered, asserted in the same cycle count updates, and high for exactly 1 cycle.
- REQ-023 count SHALL never exceed MAX_COUNT.
- REQ-024 A held button SHALL produce exactly one step (no auto-repeat).

Reset
- REQ-025 While rst=0 at a clk edge: count=0, ovf=0, unf=0, synchroniser flops=0, debounce run counters=0, accepted levels=0, edge history=0.
- REQ-026 A button held through reset release SHALL produce exactly one step, BOUNCING_TIME+4 cycles after release.
- REQ-027 Reset asserted mid-debounce SHALL discard the partial run; no pulse attributable to pre-reset activity.

Structure
- REQ-028 A shared package SHALL hold the step-code encoding (HOLD, INC, DEC, CLR) and the default BOUNCING_TIME constant.
- REQ-029 Sub-module btn_pulse (synchroniser + debouncer + edge detector, parameter BOUNCING_TIME) SHALL be instantiated once per button.
- REQ-030 Debounce counter width SHALL be $clog2(BOUNCING_TIME+1).

Verification (BOUNCING_TIME=4, WIDTH=4)
- REQ-031 MAX_COUNT=9, WRAP=1: ten clean up presses from reset -> count steps 1..9 then 0; ovf pulses once on the tenth press.
- REQ-032 WRAP=0, MAX_COUNT=15: dn press at count=0 -> count stays 0, unf pulses 1 cycle; sixteen up presses -> count=15 and ovf pulses on the 16th.
- REQ-033 btn_up toggling every 2 cycles for 20 cycles, then held high -> exactly one increment, at cycle 8 after the last toggle.
- REQ-034 up and dn rising on the same cycle at count=5 -> count stays 5; up and clr together at count=7 -> count=0, ovf=0.
- REQ-035 btn_up held 100 cycles at count=3 -> count=4 only; release then re-press -> count=5.
- REQ-036 rst=0 for 1 cycle at count=6 while btn_dn is mid-debounce (2 stable cycles) -> count=0 next cycle; btn_dn held -> count=MAX_COUNT 8 cycles after rst=1 (WRAP=1).
